// File: rtl/key_interrupt_receiver_if.sv
// Signal bundle between the key-event source / CPU side and key_interrupt_receiver.
// master drives key events, frame ticks and CPU handshakes; slave is the receiver.
interface key_interrupt_receiver_if #(
    parameter int unsigned CNT_W = 4
);
    logic             key_interrupt;
    logic             frame_tick;
    logic             irq_ack;
    logic             clear_overflow;
    logic             irq;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             frame_jump;
    logic [15:0]      delivered_count;

    modport master (
        output key_interrupt, frame_tick, irq_ack, clear_overflow,
        input  irq, pending, overflow, frame_jump, delivered_count
    );

    modport slave (
        input  key_interrupt, frame_tick, irq_ack, clear_overflow,
        output irq, pending, overflow, frame_jump, delivered_count
    );
endinterface

// File: rtl/key_interrupt_receiver.sv
// Edge-detects key_interrupt into a saturating pending queue and delivers events
// to the CPU as a level irq with ack, rate-limited per frame; tracks per-frame activity.
module key_interrupt_receiver #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned MAX_PER_FRAME = 1
) (
    input logic                    clock,
    input logic                    reset,
    key_interrupt_receiver_if.slave bus
);
    localparam int unsigned      BUD_W    = $clog2(MAX_PER_FRAME + 1);
    localparam logic [BUD_W-1:0] BUD_MAX  = BUD_W'(MAX_PER_FRAME);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             key_q;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             seen_q, seen_d;
    logic             frame_jump_q, frame_jump_d;
    logic [BUD_W-1:0] budget_q, budget_d;
    logic [15:0]      delivered_q, delivered_d;
    logic             evt;
    logic             deliver;
    logic             ovf_set;

    always_comb begin
        evt          = bus.key_interrupt & ~key_q;
        deliver      = (state_q == ASSERT) & bus.irq_ack;
        ovf_set      = 1'b0;
        pending_d    = pending_q;
        state_d      = state_q;
        budget_d     = budget_q;
        delivered_d  = delivered_q;
        seen_d       = seen_q;
        frame_jump_d = frame_jump_q;

        if (evt && !deliver) begin
            if (pending_q == PEND_MAX) ovf_set = 1'b1;
            else                       pending_d = pending_q + CNT_W'(1);
        end else if (deliver && !evt) begin
            pending_d = pending_q - CNT_W'(1);
        end
        // A lost event in the same cycle as a clear keeps the flag set.
        overflow_d = ovf_set | (overflow_q & ~bus.clear_overflow);

        case (state_q)
            IDLE:    if (pending_q != '0 && budget_q != '0) state_d = ASSERT;
            ASSERT:  if (bus.irq_ack) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (deliver) begin
            budget_d    = budget_q - BUD_W'(1);
            delivered_d = delivered_q + 16'd1;
        end
        if (bus.frame_tick) budget_d = BUD_MAX;

        // An event on the tick cycle belongs to the frame being closed.
        if (bus.frame_tick) begin
            frame_jump_d = seen_q | evt;
            seen_d       = 1'b0;
        end else if (evt) begin
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            key_q        <= 1'b0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
            seen_q       <= 1'b0;
            frame_jump_q <= 1'b0;
            budget_q     <= BUD_MAX;
            delivered_q  <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= bus.key_interrupt;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            seen_q       <= seen_d;
            frame_jump_q <= frame_jump_d;
            budget_q     <= budget_d;
            delivered_q  <= delivered_d;
        end
    end

    assign bus.irq             = (state_q == ASSERT);
    assign bus.pending         = pending_q;
    assign bus.overflow        = overflow_q;
    assign bus.frame_jump      = frame_jump_q;
    assign bus.delivered_count = delivered_q;
endmodule

// File: tb/tb_key_interrupt_receiver.sv
// Scoreboard bench for key_interrupt_receiver (CNT_W=2, MAX_PER_FRAME=1): every output
// change is matched against a queued expected snapshot and the cycle it must appear in.
module tb_key_interrupt_receiver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;
    logic mon_en   = 1'b0;

    key_interrupt_receiver_if #(.CNT_W(2)) bus ();

    key_interrupt_receiver #(
        .CNT_W        (2),
        .MAX_PER_FRAME(1)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct packed {
        logic        irq;
        logic [1:0]  pend;
        logic        ovf;
        logic        fj;
        logic [15:0] dc;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
        string tag;
    } exp_t;

    exp_t sb[$];

    function automatic snap_t sample();
        snap_t s;
        s.irq  = bus.irq;
        s.pend = bus.pending;
        s.ovf  = bus.overflow;
        s.fj   = bus.frame_jump;
        s.dc   = bus.delivered_count;
        return s;
    endfunction

    // Expected output snapshot, due dly rising edges from now.
    task automatic expect_out(input logic i, input logic [1:0] p, input logic o,
                              input logic f, input logic [15:0] d, input int dly,
                              input string tag);
        exp_t e;
        e.s.irq  = i;
        e.s.pend = p;
        e.s.ovf  = o;
        e.s.fj   = f;
        e.s.dc   = d;
        e.cyc    = cyc_n + dly;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        snap_t s;
        s = sample();
        checks++;
        if (s !== '0) begin
            failures++;
            $display("FAIL %s: got irq=%0b pend=%0d ovf=%0b fj=%0b dc=%0d, expected all zero",
                     tag, s.irq, s.pend, s.ovf, s.fj, s.dc);
        end
    endtask

    snap_t prev;
    logic  prev_ok = 1'b0;

    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        if (!mon_en) begin
            prev_ok = 1'b0;
        end else begin
            cur = sample();
            if (!prev_ok) begin
                prev    = cur;
                prev_ok = 1'b1;
            end else if (cur !== prev) begin
                prev = cur;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: got irq=%0b pend=%0d ovf=%0b fj=%0b dc=%0d @%0d, expected no change",
                             cur.irq, cur.pend, cur.ovf, cur.fj, cur.dc, cyc_n);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.s || cyc_n != e.cyc) begin
                        failures++;
                        $display("FAIL %s: got irq=%0b pend=%0d ovf=%0b fj=%0b dc=%0d @%0d, expected irq=%0b pend=%0d ovf=%0b fj=%0b dc=%0d @%0d",
                                 e.tag, cur.irq, cur.pend, cur.ovf, cur.fj, cur.dc, cyc_n,
                                 e.s.irq, e.s.pend, e.s.ovf, e.s.fj, e.s.dc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_interrupt  = 1'b0;
        bus.frame_tick     = 1'b0;
        bus.irq_ack        = 1'b0;
        bus.clear_overflow = 1'b0;
        #1 rst = 1'b1;
        step(3);
        check_zero("reset_state");
        rst    = 1'b0;
        mon_en = 1'b1;
        step(2);

        // 1: key held 5 cycles, ack 3 cycles after irq rises
        expect_out(0, 1, 0, 0, 0, 1, "t1_pend");
        expect_out(1, 1, 0, 0, 0, 2, "t1_irq");
        bus.key_interrupt = 1'b1;
        step(4);
        expect_out(0, 0, 0, 0, 1, 1, "t1_ack");
        bus.irq_ack = 1'b1;
        step(1); bus.key_interrupt = 1'b0; bus.irq_ack = 1'b0;
        step(1);
        expect_out(0, 0, 0, 1, 1, 1, "t2_tick0");
        bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(2);

        // 2: three events in one frame, one delivery per tick
        expect_out(0, 1, 0, 1, 1, 1, "t2_ev1");
        expect_out(1, 1, 0, 1, 1, 2, "t2_irq1");
        bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); expect_out(1, 2, 0, 1, 1, 1, "t2_ev2"); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); expect_out(1, 3, 0, 1, 1, 1, "t2_ev3"); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(2); expect_out(0, 2, 0, 1, 2, 1, "t2_ack1"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(5);
        expect_out(1, 2, 0, 1, 2, 2, "t2_irq2");
        bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(1); expect_out(0, 1, 0, 1, 3, 1, "t2_ack2"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(3);
        expect_out(0, 1, 0, 0, 3, 1, "t2_fj0");
        expect_out(1, 1, 0, 0, 3, 2, "t2_irq3");
        bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(1); expect_out(0, 0, 0, 0, 4, 1, "t2_ack3"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(3);

        // 4: event and ack in the same cycle with pending=2
        expect_out(0, 1, 0, 0, 4, 1, "t4_ev1"); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); expect_out(0, 2, 0, 0, 4, 1, "t4_ev2"); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1);
        expect_out(0, 2, 0, 1, 4, 1, "t4_fj");
        expect_out(1, 2, 0, 1, 4, 2, "t4_irq");
        bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(1);
        expect_out(0, 2, 0, 1, 5, 1, "t4_ev_ack");
        bus.key_interrupt = 1'b1; bus.irq_ack = 1'b1;
        step(1); bus.key_interrupt = 1'b0; bus.irq_ack = 1'b0;
        step(3);

        // 5: frame flag, including an event on the tick cycle
        expect_out(1, 2, 0, 1, 5, 2, "t5_irq_a"); bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(1); expect_out(0, 1, 0, 1, 6, 1, "t5_ack_a"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(3);
        expect_out(0, 1, 0, 0, 6, 1, "t5_fj0_a");
        expect_out(1, 1, 0, 0, 6, 2, "t5_irq_b");
        bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(1); expect_out(0, 0, 0, 0, 7, 1, "t5_ack_b"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(3);
        expect_out(0, 1, 0, 1, 7, 1, "t5_tick_ev");
        expect_out(1, 1, 0, 1, 7, 2, "t5_irq_c");
        bus.key_interrupt = 1'b1; bus.frame_tick = 1'b1;
        step(1); bus.key_interrupt = 1'b0; bus.frame_tick = 1'b0;
        step(1); expect_out(0, 0, 0, 1, 8, 1, "t5_ack_c"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(3);
        expect_out(0, 0, 0, 0, 8, 1, "t5_fj0_b"); bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(2);

        // 3: saturation and overflow priority (CNT_W=2)
        expect_out(0, 1, 0, 0, 8, 1, "t3_ev1");
        expect_out(1, 1, 0, 0, 8, 2, "t3_irq");
        bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); expect_out(1, 2, 0, 0, 8, 1, "t3_ev2"); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); expect_out(1, 3, 0, 0, 8, 1, "t3_ev3"); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); expect_out(1, 3, 1, 0, 8, 1, "t3_ovf"); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); bus.key_interrupt = 1'b1; bus.clear_overflow = 1'b1;
        step(1); bus.key_interrupt = 1'b0; bus.clear_overflow = 1'b0;
        step(2); expect_out(1, 3, 0, 0, 8, 1, "t3_clr"); bus.clear_overflow = 1'b1;
        step(1); bus.clear_overflow = 1'b0;
        step(2);

        // 6: async reset while irq=1 and pending=2
        expect_out(0, 2, 0, 0, 9, 1, "t6_ack"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(3);
        expect_out(0, 2, 0, 1, 9, 1, "t6_fj");
        expect_out(1, 2, 0, 1, 9, 2, "t6_irq");
        bus.frame_tick = 1'b1;
        step(1); bus.frame_tick = 1'b0;
        step(3);
        mon_en = 1'b0;
        #2 rst = 1'b1; bus.irq_ack = 1'b1;
        #1 check_zero("t6_reset_async");
        step(1); rst = 1'b0;
        step(1); mon_en = 1'b1;
        step(2); bus.irq_ack = 1'b0;
        step(1);
        expect_out(0, 1, 0, 0, 0, 1, "t6_ev");
        expect_out(1, 1, 0, 0, 0, 2, "t6_irq_post");
        bus.key_interrupt = 1'b1;
        step(1); bus.key_interrupt = 1'b0;
        step(1); expect_out(0, 0, 0, 0, 1, 1, "t6_ack_post"); bus.irq_ack = 1'b1;
        step(1); bus.irq_ack = 1'b0;
        step(4);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d outstanding entries (next %s), expected 0",
                     sb.size(), sb[0].tag);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
